// File: rtl/scene_pkg.sv
// Shared types and scene byte layout for the double-buffered scene register file.
// Field offsets are byte lanes only; consumers apply sign and Q-format interpretation.
package scene_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        PENDING = 1'b1
    } state_t;

    localparam int NUM_BYTES_DEF = 64;

    // 16-bit fields occupy two consecutive bytes, low byte first.
    localparam int OFF_X_V0        = 0;
    localparam int OFF_Y_V0        = 2;
    localparam int OFF_Z_V0        = 4;
    localparam int OFF_X_V1        = 6;
    localparam int OFF_Y_V1        = 8;
    localparam int OFF_Z_V1        = 10;
    localparam int OFF_X_V2        = 12;
    localparam int OFF_Y_V2        = 14;
    localparam int OFF_Z_V2        = 16;
    localparam int OFF_ROT_X       = 18;
    localparam int OFF_ROT_Y       = 20;
    localparam int OFF_ROT_Z       = 22;
    localparam int OFF_CAM_Z       = 24;
    localparam int OFF_SCALE       = 26;
    localparam int OFF_COLOR_V0    = 28;
    localparam int OFF_COLOR_V1    = 29;
    localparam int OFF_COLOR_V2    = 30;
    localparam int OFF_RENDER_MODE = 31;
    localparam int OFF_CKSUM       = NUM_BYTES_DEF - 1;

    localparam int WORLD_Q_INT  = 8;
    localparam int WORLD_Q_FRAC = 8;
    localparam int ANGLE_W      = 16;
    localparam int CAM_Q_INT    = 8;
    localparam int CAM_Q_FRAC   = 8;
    localparam int SCALE_Q_INT  = 4;
    localparam int SCALE_Q_FRAC = 12;

    function automatic logic [7:0] cksum_add(input logic [7:0] sum, input logic [7:0] data);
        return sum + data;
    endfunction

endpackage

// File: rtl/scene_pkt_checker.sv
// Tracks which bytes of the current packet arrived and their running checksum,
// and judges the packet on pkt_done including any write landing on that same edge.
module scene_pkt_checker
    import scene_pkg::*;
#(
    parameter int NUM_BYTES = NUM_BYTES_DEF,
    parameter int IDX_W     = 7,
    parameter int CKSUM_EN  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [7:0]       i_wr_data,
    input  logic             i_clear,
    input  logic             i_pkt_done,
    output logic             o_valid,
    output logic             o_invalid
);

    logic [NUM_BYTES-1:0] r_mask;
    logic [NUM_BYTES-1:0] w_hit;
    logic [NUM_BYTES-1:0] w_mask_next;
    logic [7:0]           r_sum;
    logic [7:0]           w_sum_next;
    logic [7:0]           r_cksum;
    logic [7:0]           w_cksum_next;
    logic                 w_good;

    // Out-of-range indices match no lane, so they are dropped without a flag.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_hit
            assign w_hit[gi] = i_wr_en && (i_wr_idx == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        w_mask_next  = r_mask | w_hit;
        w_sum_next   = r_sum;
        w_cksum_next = r_cksum;
        if ((CKSUM_EN != 0) && (|w_hit[NUM_BYTES-2:0]))
            w_sum_next = cksum_add(r_sum, i_wr_data);
        if (w_hit[NUM_BYTES-1])
            w_cksum_next = i_wr_data;
        w_good = (&w_mask_next) && ((CKSUM_EN == 0) || (w_sum_next == w_cksum_next));
    end

    assign o_valid   = i_pkt_done &&  w_good;
    assign o_invalid = i_pkt_done && !w_good;

    // The checksum byte copy mirrors the shadow lane, so it is never cleared mid-run.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask  <= '0;
            r_sum   <= '0;
            r_cksum <= '0;
        end else begin
            r_cksum <= w_cksum_next;
            if (i_clear || i_pkt_done) begin
                r_mask <= '0;
                r_sum  <= '0;
            end else begin
                r_mask <= w_mask_next;
                r_sum  <= w_sum_next;
            end
        end
    end

endmodule

// File: rtl/scene_reg_bank.sv
// Double-buffered scene registers: bytes collect in a shadow bank and a validated
// packet is copied to the active bank only on a frame boundary.
module scene_reg_bank
    import scene_pkg::*;
#(
    parameter int NUM_BYTES = NUM_BYTES_DEF,
    parameter int IDX_W     = 7,
    parameter int CKSUM_EN  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_wr_en,
    input  logic [IDX_W-1:0]       i_wr_idx,
    input  logic [7:0]             i_wr_data,
    input  logic                   i_pkt_done,
    input  logic                   i_frame_start,
    output logic [NUM_BYTES*8-1:0] o_regs_flat,
    output logic                   o_data_ready,
    output logic                   o_pending,
    output logic                   o_cksum_err,
    output logic                   o_overrun
);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_shadow [NUM_BYTES];
    logic [7:0] r_active [NUM_BYTES];
    logic       r_data_ready;
    logic       r_cksum_err;
    logic       r_overrun;
    logic       w_collect;
    logic       w_commit;
    logic       w_valid;
    logic       w_invalid;

    assign w_collect = (r_state == COLLECT);

    scene_pkt_checker #(
        .NUM_BYTES (NUM_BYTES),
        .IDX_W     (IDX_W),
        .CKSUM_EN  (CKSUM_EN)
    ) u_checker (
        .clk        (clk),
        .reset      (reset),
        .i_wr_en    (i_wr_en && w_collect),
        .i_wr_idx   (i_wr_idx),
        .i_wr_data  (i_wr_data),
        .i_clear    (w_commit),
        .i_pkt_done (i_pkt_done && w_collect),
        .o_valid    (w_valid),
        .o_invalid  (w_invalid)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= COLLECT;
        else       r_state <= w_state_next;
    end

    // frame_start is only looked at once PENDING, so a coincident pkt_done waits a frame.
    always_comb begin
        w_state_next = r_state;
        w_commit     = 1'b0;
        case (r_state)
            COLLECT: if (w_valid) w_state_next = PENDING;
            PENDING: begin
                if (i_frame_start) begin
                    w_commit     = 1'b1;
                    w_state_next = COLLECT;
                end
            end
            default: w_state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                r_shadow[k] <= '0;
                r_active[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (w_collect && i_wr_en && (i_wr_idx == IDX_W'(k)))
                    r_shadow[k] <= i_wr_data;
                if (w_commit)
                    r_active[k] <= r_shadow[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_ready <= 1'b0;
            r_cksum_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_data_ready <= w_commit;
            r_cksum_err  <= w_invalid;
            if (!w_collect && i_wr_en)
                r_overrun <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_flat
            assign o_regs_flat[8*gi +: 8] = r_active[gi];
        end
    endgenerate

    assign o_data_ready = r_data_ready;
    assign o_pending    = !w_collect;
    assign o_cksum_err  = r_cksum_err;
    assign o_overrun    = r_overrun;

endmodule
